// File: rtl/bcd16_to_bin14_if.sv
// Handshake/data bundle for the 4-digit BCD to 14-bit binary converter.
//   en        : start strobe (master -> slave)
//   bcd_d_in  : packed BCD operand, [15:12] thousands .. [3:0] ones (master -> slave)
//   bin_d_out : registered binary result, held between conversions (slave -> master)
//   rdy       : one-cycle completion pulse (slave -> master)
//   busy      : conversion in progress, DONE included (slave -> master)
//   err       : invalid-digit flag, valid with rdy (slave -> master)
interface bcd16_to_bin14_if;
  logic        en;
  logic [15:0] bcd_d_in;
  logic [13:0] bin_d_out;
  logic        rdy;
  logic        busy;
  logic        err;

  modport master (
    output en, bcd_d_in,
    input  bin_d_out, rdy, busy, err
  );

  modport slave (
    input  en, bcd_d_in,
    output bin_d_out, rdy, busy, err
  );
endinterface

// File: rtl/bcd16_to_bin14.sv
// Sequential 4-digit packed BCD to 14-bit binary converter (reverse double-dabble).
// Each of 14 SHIFT steps moves the working register right by one; between shifts a
// SUB step takes 3 from every BCD nibble that is 8 or more. Valid input: 29 clocks
// from en to rdy, one conversion per 30 clocks with en held high.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd16_to_bin14_if.slave (en, bcd_d_in, bin_d_out, rdy, busy, err)
// Optional feature: define BCD16_TO_BIN14_DIGIT_CHECK_EN to reject inputs holding a
// nibble above 9 (rdy after 2 clocks with err=1, bin_d_out=0). Without it err is 0.
module bcd16_to_bin14 (
  input logic              clk,
  input logic              rst_n,
  bcd16_to_bin14_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StShift = 3'd2,
    StSub   = 3'd3,
    StDone  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] sr_q, sr_d;        // {bcd part [29:14], binary part [13:0]}
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic [13:0] bin_q, bin_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
  logic        err_q, err_d;
  logic        bad_q, bad_d;      // remembers a failed digit check until DONE
`endif

  // Nibble correction: a digit that became >= 8 after a right shift held a
  // borrowed 10 that must read as 5, hence the -3 (no borrow across nibbles).
  function automatic logic [3:0] sub3(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [15:0] b);
    return (b[15:12] > 4'd9) || (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    sh_cnt_d = sh_cnt_q;
    bin_d    = bin_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
    err_d    = err_q;
    bad_d    = bad_q;
`endif

    case (state_q)
      StIdle: begin
        busy_d = bus.en;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
        err_d  = 1'b0;
`endif
        if (bus.en) begin
          sr_d     = {bus.bcd_d_in, 14'b0};
          sh_cnt_d = 4'd0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
        bad_d   = has_bad_digit(sr_q[29:14]);
        state_d = has_bad_digit(sr_q[29:14]) ? StDone : StShift;
`else
        state_d = StShift;
`endif
      end
      StShift: begin
        sr_d     = sr_q >> 1;
        sh_cnt_d = sh_cnt_q + 4'd1;
        state_d  = (sh_cnt_q == 4'd13) ? StDone : StSub;
      end
      StSub: begin
        sr_d    = {sub3(sr_q[29:26]), sub3(sr_q[25:22]), sub3(sr_q[21:18]),
                   sub3(sr_q[17:14]), sr_q[13:0]};
        state_d = StShift;
      end
      StDone: begin
        rdy_d   = 1'b1;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
        bin_d   = bad_q ? 14'd0 : sr_q[13:0];
        err_d   = bad_q;
`else
        bin_d   = sr_q[13:0];
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sr_q     <= 30'd0;
      sh_cnt_q <= 4'd0;
      bin_q    <= 14'd0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      sh_cnt_q <= sh_cnt_d;
      bin_q    <= bin_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
      err_q    <= err_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign bus.bin_d_out = bin_q;
  assign bus.rdy       = rdy_q;
  assign bus.busy      = busy_q;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
